control_fsm_module: RTL and testbench
=====================================

CONTROL_FSM_MODULE -- requirements
Module: control_fsm_module

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning the maximum number of wait cycles for mem_op_r before trapping.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- ir_reg_out  in  32  current instruction
- zero  in  1  ALU zero flag
- mem_op_r  in  1  memory operation complete
- pc_enable, old_pc_enable, ir_reg_enable, alu_reg_enable, rf_we  out  1 each  register load enables
- mem_enable, mem_write_enable  out  1 each  memory request, write qualifier
- memsel_mux_select, regfile_mux_select, alu_reg_mux_select  out  1 each  mux selects
- opsel1_select, opsel2_select  out  2 each  ALU operand selects
- imm_src, alu_sel  out  3 each  immediate format, ALU operation
- illegal_insn  out  1  sticky trap flag
REQ-003 SHALL use one clock (clk) and a synchronous, active-high reset (reset).

Function
REQ-004 SHALL be a Moore FSM, plus Mealy qualification on mem_op_r in FETCH, MEMREAD and MEMWRITE; any output not listed for a state SHALL be 0.
REQ-005 Encodings:
- opsel1: 00 rs1, 01 pc, 10 old_pc, 11 zero
- opsel2: 00 imm, 01 const 4, 10 rs2
- imm_src: I 000, S 001, B 010, U 011, J 100
- alu_sel: ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLL 110, SRL 111
REQ-006 FETCH: mem_enable=1, memsel=0. When mem_op_r=1: ir_reg_enable=1, old_pc_enable=1, pc_enable=1, opsel1=01, opsel2=01, ADD, alu_reg_mux_select=1; next state DECODE. Otherwise stay.
REQ-007 DECODE: opsel1=10, opsel2=00, ADD, alu_reg_enable=1; imm_src=J for opcode 1101111, else B. Next state by opcode:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR
- 0110111 or 0010111 -> UTYPE
- any other opcode -> TRAP
REQ-008 MEMADR: opsel1=00, opsel2=00, ADD, alu_reg_enable=1; imm_src=S for stores, I for loads; next state MEMWRITE (store) or MEMREAD (load).
REQ-009 MEMREAD: mem_enable=1, memsel=1, alu_reg_mux_select=0. When mem_op_r=1: rf_we=1, regfile_mux_select=0; next state FETCH.
REQ-010 MEMWRITE: mem_enable=1, mem_write_enable=1, memsel=1, alu_reg_mux_select=0; next state FETCH when mem_op_r=1.
REQ-011 EXEC_R: opsel1=00, opsel2=10, alu_reg_enable=1; alu_sel from funct3 (000 ADD/SUB by ir[30], 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL, 101 SRL); next state ALUWB.
REQ-012 EXEC_I: as EXEC_R, except opsel2=00, imm_src=I, and funct3 000 is always ADD.
REQ-013 Unsupported funct3 (011) in EXEC_R or EXEC_I SHALL go to TRAP; its outputs in that state SHALL all be 0.
REQ-014 ALUWB: rf_we=1, regfile_mux_select=1, alu_reg_mux_select=0; next state FETCH.
REQ-015 BRANCH: opsel1=00, opsel2=10, SUB. Branch is taken if (funct3=000 and zero=1) or (funct3=001 and zero=0). Taken: pc_enable=1, alu_reg_mux_select=0. Next state FETCH. Other funct3 values -> TRAP.
REQ-016 JAL: pc_enable=1, alu_reg_mux_select=0, opsel1=10, opsel2=01, ADD, alu_reg_enable=1; next state ALUWB.
REQ-017 JALR: opsel1=00, opsel2=00, imm_src=I, ADD, alu_reg_mux_select=1, pc_enable=1; next state LINK. Target LSB SHALL NOT be masked.
REQ-018 LINK: opsel1=10, opsel2=01, ADD, alu_reg_enable=1; next state ALUWB.
REQ-019 UTYPE: opsel1=11 (LUI) or 10 (AUIPC), opsel2=00, imm_src=U, ADD, alu_reg_enable=1; next state ALUWB.
REQ-020 An 8-bit wait counter SHALL clear on entry to FETCH, MEMREAD or MEMWRITE and increment each cycle mem_op_r=0 in those states. Reaching MEM_TIMEOUT SHALL go to TRAP.
REQ-021 TRAP: illegal_insn=1, all other outputs 0; SHALL remain in TRAP until reset.

Reset
REQ-022 While reset=1, all outputs SHALL be 0 and illegal_insn SHALL be 0.
REQ-023 On the clock edge with reset=1, state SHALL become FETCH and the counter 0, from any state, including mid-memory-wait.

Structure
REQ-024 A shared package SHALL hold the state enum, opcode constants, and the imm_src, alu_sel and opsel encodings.
REQ-025 Sub-module alu_decoder_module SHALL map funct3, ir[30] and an R/I flag to alu_sel plus an invalid flag.

Verification
REQ-026 addi x1,x0,5 (0x00500093), mem_op_r after 2 cycles: FETCH(3 cycles) -> DECODE -> EXEC_I (alu_sel=000, imm_src=000) -> ALUWB with rf_we=1 -> FETCH.
REQ-027 beq with zero=1: BRANCH asserts pc_enable=1, alu_reg_mux_select=0. Same instruction with zero=0: pc_enable=0.
REQ-028 sw (0x0020A023): MEMADR imm_src=001, then MEMWRITE asserts mem_write_enable=1 until mem_op_r, then FETCH.
REQ-029 jalr: JALR pc_enable=1 -> LINK opsel1=10, opsel2=01 -> ALUWB rf_we=1.
REQ-030 Opcode 0x7F -> TRAP with illegal_insn=1. mem_op_r held 0 for 255 cycles in FETCH -> TRAP. Reset then returns to FETCH with illegal_insn=0.
REQ-031 Reset asserted in MEMREAD mid-wait: all outputs 0 that cycle, next state FETCH, no rf_we pulse.

Source files
------------

// File: rtl/control_fsm_module_pkg.sv
// Shared definitions for the multicycle control FSM: state encoding, opcodes,
// datapath select encodings and the packed control word driven each cycle.
package control_fsm_module_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_EXEC_R   = 4'd5,
    S_EXEC_I   = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_LINK     = 4'd11,
    S_UTYPE    = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] OPSEL1_RS1    = 2'b00;
  localparam logic [1:0] OPSEL1_PC     = 2'b01;
  localparam logic [1:0] OPSEL1_OLD_PC = 2'b10;
  localparam logic [1:0] OPSEL1_ZERO   = 2'b11;

  localparam logic [1:0] OPSEL2_IMM  = 2'b00;
  localparam logic [1:0] OPSEL2_FOUR = 2'b01;
  localparam logic [1:0] OPSEL2_RS2  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef struct packed {
    logic       pc_enable;
    logic       old_pc_enable;
    logic       ir_reg_enable;
    logic       alu_reg_enable;
    logic       rf_we;
    logic       mem_enable;
    logic       mem_write_enable;
    logic       memsel_mux_select;
    logic       regfile_mux_select;
    logic       alu_reg_mux_select;
    logic [1:0] opsel1_select;
    logic [1:0] opsel2_select;
    logic [2:0] imm_src;
    logic [2:0] alu_sel;
    logic       illegal_insn;
  } ctrl_t;

  // States in which the FSM waits on mem_op_r and the timeout counter runs.
  function automatic logic is_mem_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/control_fsm_module_alu_decoder.sv
// Maps funct3 / ir[30] to an ALU operation; flags funct3 encodings the
// datapath does not implement so the FSM can trap on them.
module alu_decoder_module
  import control_fsm_module_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       bit30,
  input  logic       is_rtype,
  output logic [2:0] alu_sel,
  output logic       invalid
);

  always_comb begin
    alu_sel = ALU_ADD;
    invalid = 1'b0;
    unique case (funct3)
      // Immediate forms have no subtract, so ir[30] only matters for R-type.
      3'b000: alu_sel = (is_rtype && bit30) ? ALU_SUB : ALU_ADD;
      3'b001: alu_sel = ALU_SLL;
      3'b010: alu_sel = ALU_SLT;
      3'b011: invalid = 1'b1;
      3'b100: alu_sel = ALU_XOR;
      3'b101: alu_sel = ALU_SRL;
      3'b110: alu_sel = ALU_OR;
      3'b111: alu_sel = ALU_AND;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_fsm_module.sv
// Multicycle RV32 subset control unit: Moore FSM with mem_op_r qualification in
// the memory-wait states, a wait timeout and a sticky illegal-instruction trap.
module control_fsm_module
  import control_fsm_module_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_reg_out,
  input  logic        zero,
  input  logic        mem_op_r,
  output logic        pc_enable,
  output logic        old_pc_enable,
  output logic        ir_reg_enable,
  output logic        alu_reg_enable,
  output logic        rf_we,
  output logic        mem_enable,
  output logic        mem_write_enable,
  output logic        memsel_mux_select,
  output logic        regfile_mux_select,
  output logic        alu_reg_mux_select,
  output logic [1:0]  opsel1_select,
  output logic [1:0]  opsel2_select,
  output logic [2:0]  imm_src,
  output logic [2:0]  alu_sel,
  output logic        illegal_insn
);

  // Memory handshake: mem_enable is held high for the whole request and the
  // memory answers with a single-cycle mem_op_r; the request completes on the
  // cycle where both are high, and the FSM advances on that clock edge.

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  ctrl_t       ctrl;
  ctrl_t       ctrl_out;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [2:0]  dec_alu_sel;
  logic        dec_invalid;
  logic        wait_timeout;
  logic        unused_ir;

  assign opcode    = ir_reg_out[6:0];
  assign funct3    = ir_reg_out[14:12];
  assign unused_ir = ^{ir_reg_out[31], ir_reg_out[29:15], ir_reg_out[11:7]};

  alu_decoder_module u_alu_decoder (
    .funct3   (funct3),
    .bit30    (ir_reg_out[30]),
    .is_rtype (opcode == OP_RTYPE),
    .alu_sel  (dec_alu_sel),
    .invalid  (dec_invalid)
  );

  // The count after this cycle's miss would reach the limit.
  assign wait_timeout = ({1'b0, wait_cnt} + 9'd1) >= 9'(MEM_TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_next;
      if ((state_next != state) && is_mem_wait_state(state_next)) begin
        wait_cnt <= 8'd0;
      end else if (is_mem_wait_state(state) && !mem_op_r) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    ctrl       = '0;
    state_next = state;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_enable = 1'b1;
        if (mem_op_r) begin
          ctrl.ir_reg_enable      = 1'b1;
          ctrl.old_pc_enable      = 1'b1;
          ctrl.pc_enable          = 1'b1;
          ctrl.opsel1_select      = OPSEL1_PC;
          ctrl.opsel2_select      = OPSEL2_FOUR;
          ctrl.alu_sel            = ALU_ADD;
          ctrl.alu_reg_mux_select = 1'b1;
          state_next              = S_DECODE;
        end else if (wait_timeout) begin
          state_next = S_TRAP;
        end
      end

      S_DECODE: begin
        // Speculatively form the branch/jump target from old_pc.
        ctrl.opsel1_select  = OPSEL1_OLD_PC;
        ctrl.opsel2_select  = OPSEL2_IMM;
        ctrl.alu_sel        = ALU_ADD;
        ctrl.alu_reg_enable = 1'b1;
        ctrl.imm_src        = (opcode == OP_JAL) ? IMM_J : IMM_B;
        unique case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXEC_R;
          OP_ITYPE:          state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI, OP_AUIPC:  state_next = S_UTYPE;
          default:           state_next = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        ctrl.opsel1_select  = OPSEL1_RS1;
        ctrl.opsel2_select  = OPSEL2_IMM;
        ctrl.alu_sel        = ALU_ADD;
        ctrl.alu_reg_enable = 1'b1;
        ctrl.imm_src        = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_next          = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD: begin
        ctrl.mem_enable        = 1'b1;
        ctrl.memsel_mux_select = 1'b1;
        if (mem_op_r) begin
          ctrl.rf_we = 1'b1;
          state_next = S_FETCH;
        end else if (wait_timeout) begin
          state_next = S_TRAP;
        end
      end

      S_MEMWRITE: begin
        ctrl.mem_enable        = 1'b1;
        ctrl.mem_write_enable  = 1'b1;
        ctrl.memsel_mux_select = 1'b1;
        if (mem_op_r) begin
          state_next = S_FETCH;
        end else if (wait_timeout) begin
          state_next = S_TRAP;
        end
      end

      S_EXEC_R, S_EXEC_I: begin
        if (dec_invalid) begin
          state_next = S_TRAP;
        end else begin
          ctrl.opsel1_select  = OPSEL1_RS1;
          ctrl.opsel2_select  = (state == S_EXEC_R) ? OPSEL2_RS2 : OPSEL2_IMM;
          ctrl.imm_src        = IMM_I;
          ctrl.alu_sel        = dec_alu_sel;
          ctrl.alu_reg_enable = 1'b1;
          state_next          = S_ALUWB;
        end
      end

      S_ALUWB: begin
        ctrl.rf_we              = 1'b1;
        ctrl.regfile_mux_select = 1'b1;
        state_next              = S_FETCH;
      end

      S_BRANCH: begin
        // alu_reg still holds the target computed in DECODE.
        ctrl.opsel1_select = OPSEL1_RS1;
        ctrl.opsel2_select = OPSEL2_RS2;
        ctrl.alu_sel       = ALU_SUB;
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          ctrl.pc_enable = (funct3 == 3'b000) ? zero : !zero;
          state_next     = S_FETCH;
        end else begin
          state_next = S_TRAP;
        end
      end

      S_JAL: begin
        ctrl.pc_enable      = 1'b1;
        ctrl.opsel1_select  = OPSEL1_OLD_PC;
        ctrl.opsel2_select  = OPSEL2_FOUR;
        ctrl.alu_sel        = ALU_ADD;
        ctrl.alu_reg_enable = 1'b1;
        state_next          = S_ALUWB;
      end

      S_JALR: begin
        ctrl.opsel1_select      = OPSEL1_RS1;
        ctrl.opsel2_select      = OPSEL2_IMM;
        ctrl.imm_src            = IMM_I;
        ctrl.alu_sel            = ALU_ADD;
        ctrl.alu_reg_mux_select = 1'b1;
        ctrl.pc_enable          = 1'b1;
        state_next              = S_LINK;
      end

      S_LINK: begin
        ctrl.opsel1_select  = OPSEL1_OLD_PC;
        ctrl.opsel2_select  = OPSEL2_FOUR;
        ctrl.alu_sel        = ALU_ADD;
        ctrl.alu_reg_enable = 1'b1;
        state_next          = S_ALUWB;
      end

      S_UTYPE: begin
        ctrl.opsel1_select  = (opcode == OP_LUI) ? OPSEL1_ZERO : OPSEL1_OLD_PC;
        ctrl.opsel2_select  = OPSEL2_IMM;
        ctrl.imm_src        = IMM_U;
        ctrl.alu_sel        = ALU_ADD;
        ctrl.alu_reg_enable = 1'b1;
        state_next          = S_ALUWB;
      end

      S_TRAP: begin
        ctrl.illegal_insn = 1'b1;
        state_next        = S_TRAP;
      end

      default: state_next = S_TRAP;
    endcase
  end

  assign ctrl_out = reset ? '0 : ctrl;

  assign pc_enable          = ctrl_out.pc_enable;
  assign old_pc_enable      = ctrl_out.old_pc_enable;
  assign ir_reg_enable      = ctrl_out.ir_reg_enable;
  assign alu_reg_enable     = ctrl_out.alu_reg_enable;
  assign rf_we              = ctrl_out.rf_we;
  assign mem_enable         = ctrl_out.mem_enable;
  assign mem_write_enable   = ctrl_out.mem_write_enable;
  assign memsel_mux_select  = ctrl_out.memsel_mux_select;
  assign regfile_mux_select = ctrl_out.regfile_mux_select;
  assign alu_reg_mux_select = ctrl_out.alu_reg_mux_select;
  assign opsel1_select      = ctrl_out.opsel1_select;
  assign opsel2_select      = ctrl_out.opsel2_select;
  assign imm_src            = ctrl_out.imm_src;
  assign alu_sel            = ctrl_out.alu_sel;
  assign illegal_insn       = ctrl_out.illegal_insn;

endmodule

// File: tb/tb_control_fsm_module.sv
// Self-checking bench for control_fsm_module: per-instruction expected control
// words from an instruction-level model, a vector table, and corner sequences.
module tb_control_fsm_module;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_reg_out;
  logic        zero;
  logic        mem_op_r;
  logic        pc_enable, old_pc_enable, ir_reg_enable, alu_reg_enable, rf_we;
  logic        mem_enable, mem_write_enable;
  logic        memsel_mux_select, regfile_mux_select, alu_reg_mux_select;
  logic [1:0]  opsel1_select, opsel2_select;
  logic [2:0]  imm_src, alu_sel;
  logic        illegal_insn;

  always #5 clk = ~clk;

  control_fsm_module dut (
    .clk                (clk),
    .reset              (reset),
    .ir_reg_out         (ir_reg_out),
    .zero               (zero),
    .mem_op_r           (mem_op_r),
    .pc_enable          (pc_enable),
    .old_pc_enable      (old_pc_enable),
    .ir_reg_enable      (ir_reg_enable),
    .alu_reg_enable     (alu_reg_enable),
    .rf_we              (rf_we),
    .mem_enable         (mem_enable),
    .mem_write_enable   (mem_write_enable),
    .memsel_mux_select  (memsel_mux_select),
    .regfile_mux_select (regfile_mux_select),
    .alu_reg_mux_select (alu_reg_mux_select),
    .opsel1_select      (opsel1_select),
    .opsel2_select      (opsel2_select),
    .imm_src            (imm_src),
    .alu_sel            (alu_sel),
    .illegal_insn       (illegal_insn)
  );

  localparam int W = 21;
  logic [W-1:0] act;
  assign act = {pc_enable, old_pc_enable, ir_reg_enable, alu_reg_enable, rf_we,
                mem_enable, mem_write_enable, memsel_mux_select, regfile_mux_select,
                alu_reg_mux_select, opsel1_select, opsel2_select, imm_src, alu_sel,
                illegal_insn};

  localparam logic [W-1:0] B_PC   = 21'h1 << 20;
  localparam logic [W-1:0] B_OPC  = 21'h1 << 19;
  localparam logic [W-1:0] B_IR   = 21'h1 << 18;
  localparam logic [W-1:0] B_ARE  = 21'h1 << 17;
  localparam logic [W-1:0] B_RFWE = 21'h1 << 16;
  localparam logic [W-1:0] B_MEN  = 21'h1 << 15;
  localparam logic [W-1:0] B_MWE  = 21'h1 << 14;
  localparam logic [W-1:0] B_MSEL = 21'h1 << 13;
  localparam logic [W-1:0] B_RFM  = 21'h1 << 12;
  localparam logic [W-1:0] B_ARM  = 21'h1 << 11;
  localparam logic [W-1:0] B_ILL  = 21'h1;

  function automatic logic [W-1:0] ops(input logic [1:0] o1, input logic [1:0] o2,
                                       input logic [2:0] im, input logic [2:0] al);
    return {10'b0, o1, o2, im, al, 1'b0};
  endfunction

  localparam logic [W-1:0] FETCH_DONE = B_PC | B_OPC | B_IR | B_MEN | B_ARM |
                                        {10'b0, 2'b01, 2'b01, 3'b000, 3'b000, 1'b0};

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [1:0]   in_q[$];
  string        tag_q[$];

  task automatic check(input string tag, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h (t=%0t)", tag, a, e, $time);
    end
  endtask

  task automatic push(input logic mop, input logic z, input logic [W-1:0] e,
                      input string tag);
    in_q.push_back({mop, z});
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction-level model: expands one instruction into its cycle-by-cycle
  // expected control words given the memory latencies and the zero flag.
  task automatic plan_insn(input logic [31:0] ins, input int fw, input int mw,
                           input logic z, output bit trapped);
    logic [6:0] op;
    logic [2:0] f3;
    logic [2:0] alu_tab [8];
    logic [2:0] al;
    op = ins[6:0];
    f3 = ins[14:12];
    alu_tab = '{3'd0, 3'd6, 3'd5, 3'd0, 3'd4, 3'd7, 3'd3, 3'd2};
    trapped = 1'b0;
    for (int i = 0; i < fw; i++) push(1'b0, z, B_MEN, "fetch_wait");
    push(1'b1, z, FETCH_DONE, "fetch_done");
    push(rnd(), z, B_ARE | ops(2'd2, 2'd0, (op == 7'b1101111) ? 3'd4 : 3'd2, 3'd0),
         "decode");
    case (op)
      7'b0000011, 7'b0100011: begin
        if (op == 7'b0100011) begin
          push(rnd(), z, B_ARE | ops(2'd0, 2'd0, 3'd1, 3'd0), "memadr_st");
          for (int i = 0; i < mw; i++) push(1'b0, z, B_MEN | B_MWE | B_MSEL, "memwrite_wait");
          push(1'b1, z, B_MEN | B_MWE | B_MSEL, "memwrite_done");
        end else begin
          push(rnd(), z, B_ARE | ops(2'd0, 2'd0, 3'd0, 3'd0), "memadr_ld");
          for (int i = 0; i < mw; i++) push(1'b0, z, B_MEN | B_MSEL, "memread_wait");
          push(1'b1, z, B_MEN | B_MSEL | B_RFWE, "memread_done");
        end
      end
      7'b0110011, 7'b0010011: begin
        if (f3 == 3'b011) begin
          push(rnd(), z, '0, "exec_bad_f3");
          trapped = 1'b1;
        end else begin
          al = alu_tab[f3];
          if (op == 7'b0110011 && f3 == 3'b000 && ins[30]) al = 3'd1;
          if (op == 7'b0110011) push(rnd(), z, B_ARE | ops(2'd0, 2'd2, 3'd0, al), "exec_r");
          else                  push(rnd(), z, B_ARE | ops(2'd0, 2'd0, 3'd0, al), "exec_i");
          push(rnd(), z, B_RFWE | B_RFM, "aluwb");
        end
      end
      7'b1100011: begin
        if (f3 == 3'b000 || f3 == 3'b001) begin
          push(rnd(), z, (((f3 == 3'b000) == z) ? B_PC : '0) | ops(2'd0, 2'd2, 3'd0, 3'd1),
               "branch");
        end else begin
          push(rnd(), z, ops(2'd0, 2'd2, 3'd0, 3'd1), "branch_bad_f3");
          trapped = 1'b1;
        end
      end
      7'b1101111: begin
        push(rnd(), z, B_PC | B_ARE | ops(2'd2, 2'd1, 3'd0, 3'd0), "jal");
        push(rnd(), z, B_RFWE | B_RFM, "aluwb");
      end
      7'b1100111: begin
        push(rnd(), z, B_PC | B_ARM | ops(2'd0, 2'd0, 3'd0, 3'd0), "jalr");
        push(rnd(), z, B_ARE | ops(2'd2, 2'd1, 3'd0, 3'd0), "link");
        push(rnd(), z, B_RFWE | B_RFM, "aluwb");
      end
      7'b0110111, 7'b0010111: begin
        push(rnd(), z, B_ARE | ops((op == 7'b0110111) ? 2'd3 : 2'd2, 2'd0, 3'd3, 3'd0),
             "utype");
        push(rnd(), z, B_RFWE | B_RFM, "aluwb");
      end
      default: trapped = 1'b1;
    endcase
    if (trapped) begin
      push(rnd(), z, B_ILL, "trap");
      push(rnd(), z, B_ILL, "trap_sticky");
    end
  endtask

  task automatic drain();
    logic [1:0]   iv;
    logic [W-1:0] e;
    string        t;
    while (exp_q.size() > 0) begin
      iv = in_q.pop_front();
      e  = exp_q.pop_front();
      t  = tag_q.pop_front();
      mem_op_r = iv[1];
      zero     = iv[0];
      @(negedge clk);
      check(t, act, e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    mem_op_r = rnd();
    @(negedge clk);
    check("reset_outputs", act, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_insn(input logic [31:0] ins, input int fw, input int mw,
                          input logic z, input int exp_cycles);
    bit trapped;
    ir_reg_out = ins;
    plan_insn(ins, fw, mw, z, trapped);
    if (exp_cycles >= 0) begin
      checks++;
      if (exp_q.size() != exp_cycles) begin
        errors++;
        $display("FAIL model_len ins=%h got=%0d want=%0d", ins, exp_q.size(), exp_cycles);
      end
    end
    drain();
    if (trapped) apply_reset();
  endtask

  typedef struct {
    logic [31:0] ins;
    logic        z;
    int          cycles;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [6:0] op_list [10];
    logic [31:0] ins;

    vecs = '{
      '{32'h00500093, 1'b0, 5},  // addi
      '{32'h002081B3, 1'b0, 5},  // add
      '{32'h402081B3, 1'b0, 5},  // sub
      '{32'h0020B1B3, 1'b0, 6},  // R funct3 011 -> trap
      '{32'h0050B093, 1'b0, 6},  // I funct3 011 -> trap
      '{32'h0050E093, 1'b0, 5},  // ori
      '{32'h0050D093, 1'b0, 5},  // srli
      '{32'h0000A103, 1'b0, 6},  // lw
      '{32'h0020A023, 1'b0, 6},  // sw
      '{32'h00208463, 1'b1, 4},  // beq taken
      '{32'h00208463, 1'b0, 4},  // beq not taken
      '{32'h00209463, 1'b0, 4},  // bne taken
      '{32'h0020C463, 1'b0, 6},  // blt -> trap
      '{32'h008000EF, 1'b0, 5},  // jal
      '{32'h000080E7, 1'b0, 6},  // jalr
      '{32'h123450B7, 1'b0, 5},  // lui
      '{32'h12345097, 1'b0, 5},  // auipc
      '{32'h0000007F, 1'b0, 5}   // illegal opcode
    };

    reset      = 1'b1;
    ir_reg_out = 32'h0;
    zero       = 1'b0;
    mem_op_r   = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();

    // addi with the fetch completing on its third cycle
    run_insn(32'h00500093, 2, 0, 1'b0, 6);

    foreach (vecs[i]) run_insn(vecs[i].ins, 1, 1, vecs[i].z, vecs[i].cycles);

    // Fetch never answered: 255 waiting cycles, then trap until reset.
    ir_reg_out = 32'h00500093;
    for (int i = 0; i < 255; i++) begin
      mem_op_r = 1'b0;
      @(negedge clk);
      check("timeout_wait", act, B_MEN);
      @(posedge clk);
      #1;
    end
    mem_op_r = 1'b1;
    @(negedge clk);
    check("timeout_trap", act, B_ILL);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("timeout_trap_sticky", act, B_ILL);
    @(posedge clk);
    #1;
    apply_reset();

    // One cycle short of the limit must still complete normally.
    run_insn(32'h00500093, 254, 0, 1'b0, 258);

    // Reset in the middle of a load's memory wait, with mem_op_r high.
    ir_reg_out = 32'h0000A103;
    push(1'b1, 1'b0, FETCH_DONE, "mid_fetch_done");
    push(rnd(), 1'b0, B_ARE | ops(2'd2, 2'd0, 3'd2, 3'd0), "mid_decode");
    push(rnd(), 1'b0, B_ARE | ops(2'd0, 2'd0, 3'd0, 3'd0), "mid_memadr");
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, B_MEN | B_MSEL, "mid_memread_wait");
    drain();
    reset    = 1'b1;
    mem_op_r = 1'b1;
    @(negedge clk);
    check("reset_in_memread", act, '0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    mem_op_r = 1'b0;
    @(negedge clk);
    check("fetch_after_mid_reset", act, B_MEN);
    @(posedge clk);
    #1;

    // Random instruction stream against the model.
    op_list = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};
    for (int n = 0; n < 300; n++) begin
      ins = $urandom();
      ins[6:0] = op_list[$urandom_range(0, 9)];
      if (ins[6:0] == 7'b0000000) ins[6:0] = 7'($urandom());
      run_insn(ins, $urandom_range(0, 3), $urandom_range(0, 3), rnd(), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
